modexp_seq_ctrl: RTL and testbench
==================================

Name: modexp_seq_ctrl

Overview:
- Sequencer for a single shared modular multiplier; evaluates o = m^e mod n by left-to-right square-and-multiply.
- Replaces the fully unrolled N-multiplier modexp datapath when area matters.
- Accepts one job via a req/ready handshake and issues one modmult operation at a time over a start/done handshake.
- Returns the result with a one-cycle done pulse and an error flag.

Parameters:
N, 8, operand width in bits (m, e, n, result); N >= 2.
CW, $clog2(N)+1, bit-position counter width (localparam, derived).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (low = reset)
req  in  1  job request; accepted when req && ready
ready  out  1  high only in IDLE
m  in  N  base; sampled on accept
e  in  N  exponent; sampled on accept
n  in  N  modulus; sampled on accept
o  out  N  result; valid when done=1, held until the next accept
done  out  1  one-cycle pulse at job completion
err  out  1  valid with done; 1 = job rejected (n<2 or m>=n)
mm_start  out  1  one-cycle pulse launching a multiplier op
mm_x  out  N  multiplier operand x; held stable from mm_start until mm_done
mm_y  out  N  multiplier operand y; held stable likewise
mm_n  out  N  modulus to the multiplier (latched n)
mm_o  in  N  multiplier result; sampled only when mm_done=1
mm_done  in  1  multiplier completion strobe; earliest one cycle after mm_start

Behaviour:
- Reset (rst=0, async): state=IDLE; ready=1; done=0; err=0; mm_start=0; o, mm_x, mm_y, mm_n, internal creg, ereg and cnt all 0.
- Reset mid-job aborts immediately. No done is issued for the aborted job. Any later mm_done is ignored until the next mm_start.
- IDLE: on req=1, latch m, e, n into registers and go to CHECK. req while not ready is ignored; there is no queueing.
- CHECK (1 cycle):
  - if n<2 or m>=n: o=0, err=1, go to FIN.
  - else if e==0: o=1, err=0, go to FIN.
  - else cnt=N-1, go to SCAN.
- SCAN: one exponent bit per cycle, MSB first.
  - Bit 0: shift ereg left by 1, decrement cnt, stay in SCAN.
  - Bit 1: creg=m (leading one consumed without a multiply), shift, then go to SQ_ISS if cnt>0, else go to FIN with o=creg.
- SQ_ISS (1 cycle): mm_start=1, mm_x=mm_y=creg, go to SQ_WAIT.
- SQ_WAIT: hold operands.
  - On mm_done: creg=mm_o, capture current bit b=ereg[N-1], shift ereg, decrement cnt.
  - If b=1, go to MU_ISS.
  - If b=0: go to SQ_ISS if bits remain, else FIN.
- MU_ISS (1 cycle): mm_start=1, mm_x=creg, mm_y=m_reg, go to MU_WAIT.
- MU_WAIT: on mm_done, creg=mm_o; go to SQ_ISS if bits remain, else FIN.
- FIN (1 cycle): o=creg (or the CHECK value), done=1, go to IDLE.
  - ready returns to 1 the cycle after done.
  - A req asserted in the cycle after done is accepted.
- mm_done outside SQ_WAIT/MU_WAIT is ignored. mm_start never asserts while an op is outstanding.
- Op count for a nonzero exponent with leading one at bit k: k squares plus (popcount(e)-1) multiplies.
- Cycle count with a 1-cycle multiplier: 1 (accept) + 1 (CHECK) + (N-k) SCAN + 2 per multiplier op + 1 (FIN).
- All arithmetic is delegated to the multiplier. The controller does no width growth; all registers are N bits.

Test Plan:
1. N=8, m=3, e=5, n=7, multiplier model with 1-cycle latency -> exactly 2 squares and 1 multiply; o=5, err=0; done pulses exactly once.
2. N=16, m=4, e=13, n=497, multiplier latency randomised 1..6 cycles -> o=445; mm_x and mm_y stable throughout each wait.
3. N=8, e=0, m=5, n=7 -> o=1, err=0, zero mm_start pulses. e=0x81, m=2, n=11 -> 7 squares and 1 multiply, o=2^129 mod 11=6.
4. n=1 -> err=1, o=0. n=9, m=9 -> err=1. Neither case issues any mm_start.
5. Assert req continuously during a job -> exactly one accept per job; a second job starts the cycle after done; a spurious mm_done in IDLE does not change o.
6. Pull rst low while in SQ_WAIT -> all outputs return to reset values asynchronously with no done; then release rst, complete the pending mm_done, and run job 1 again -> o=5.

Source files
------------

// File: rtl/modexp_seq_ctrl_if.sv
// Operand/result bus between the modexp sequencer and a single shared modular multiplier.
// The master drives one operation at a time; the slave answers with a done strobe.
interface modexp_seq_ctrl_if #(
  parameter int unsigned N = 8
);
  logic         mm_start;
  logic [N-1:0] mm_x;
  logic [N-1:0] mm_y;
  logic [N-1:0] mm_n;
  logic [N-1:0] mm_o;
  logic         mm_done;

  modport master (
    output mm_start, mm_x, mm_y, mm_n,
    input  mm_o, mm_done
  );

  modport slave (
    input  mm_start, mm_x, mm_y, mm_n,
    output mm_o, mm_done
  );
endinterface

// File: rtl/modexp_seq_ctrl.sv
// Left-to-right square-and-multiply sequencer computing m^e mod n on one shared modular
// multiplier. It accepts one job at a time and returns the result with a one-cycle done pulse.
module modexp_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              ready_o,
  input  logic [N-1:0]      m_i,
  input  logic [N-1:0]      e_i,
  input  logic [N-1:0]      n_i,
  output logic [N-1:0]      o_o,
  output logic              done_o,
  output logic              err_o,
  modexp_seq_ctrl_if.master mm
);
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    StIdle, StCheck, StScan, StSqIss, StSqWait, StMuIss, StMuWait, StFin
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  m_q, m_d, e_q, e_d, n_q, n_d;
  logic [N-1:0]  creg_q, creg_d, o_q, o_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      creg_q  <= '0;
      o_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      n_q     <= n_d;
      creg_q  <= creg_d;
      o_q     <= o_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // cnt holds the index of the bit at ereg[N-1]; its MSB set means it ran below zero,
  // i.e. no exponent bits remain. CW leaves room for that sign bit.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    creg_d  = creg_q;
    o_d     = o_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          m_d     = m_i;
          e_d     = e_i;
          n_d     = n_i;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((n_q[N-1:1] == '0) || (m_q >= n_q)) begin
          creg_d  = '0;
          err_d   = 1'b1;
          state_d = StFin;
        end else if (e_q == '0) begin
          creg_d  = {{(N-1){1'b0}}, 1'b1};
          state_d = StFin;
        end else begin
          cnt_d   = CW'(N - 1);
          state_d = StScan;
        end
      end
      StScan: begin
        e_d   = {e_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        // The leading one just loads the base; no multiply is needed for it.
        if (e_q[N-1]) begin
          creg_d  = m_q;
          state_d = (cnt_q != '0) ? StSqIss : StFin;
        end
      end
      StSqIss: state_d = StSqWait;
      StSqWait: begin
        if (mm.mm_done) begin
          creg_d = mm.mm_o;
          e_d    = {e_q[N-2:0], 1'b0};
          cnt_d  = cnt_q - CW'(1);
          if (e_q[N-1])            state_d = StMuIss;
          else if (cnt_q != '0)    state_d = StSqIss;
          else                     state_d = StFin;
        end
      end
      StMuIss: state_d = StMuWait;
      StMuWait: begin
        if (mm.mm_done) begin
          creg_d  = mm.mm_o;
          state_d = cnt_q[CW-1] ? StFin : StSqIss;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Operands are registered on entry to an issue state and held until the op returns.
    if (state_d == StSqIss) begin
      x_d = creg_d;
      y_d = creg_d;
    end else if (state_d == StMuIss) begin
      x_d = creg_d;
      y_d = m_q;
    end

    if (state_d == StFin) o_d = creg_d;
  end

  assign ready_o     = (state_q == StIdle);
  assign done_o      = (state_q == StFin);
  assign err_o       = err_q;
  assign o_o         = o_q;
  assign mm.mm_start = (state_q == StSqIss) || (state_q == StMuIss);
  assign mm.mm_x     = x_q;
  assign mm.mm_y     = y_q;
  assign mm.mm_n     = n_q;
endmodule

// File: tb/tb_modexp_seq_ctrl.sv
// Directed bench for modexp_seq_ctrl: an 8-bit and a 16-bit instance, each driving a
// behavioural multiplier with configurable or random latency.
module tb_modexp_seq_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A, N=8 ----------------
  logic       a_req = 1'b0;
  logic [7:0] a_m = '0, a_e = '0, a_n = '0;
  logic [7:0] a_o;
  logic       a_ready, a_done, a_err;
  modexp_seq_ctrl_if #(.N(8)) a_if ();
  modexp_seq_ctrl #(.N(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .ready_o(a_ready),
    .m_i(a_m), .e_i(a_e), .n_i(a_n), .o_o(a_o), .done_o(a_done), .err_o(a_err),
    .mm(a_if)
  );

  logic       a_mdone = 1'b0, a_spur = 1'b0;
  logic [7:0] a_mo = '0, a_x = '0, a_y = '0, a_nn = '0;
  int a_cnt = 0, a_lat = 1, a_starts = 0, a_sq = 0, a_mu = 0;
  int a_unstable = 0, a_overlap = 0, a_dones = 0, a_acc = 0;
  bit a_busy = 1'b0, a_track = 1'b0;
  assign a_if.mm_done = a_mdone | a_spur;
  assign a_if.mm_o    = a_spur ? 8'hAA : a_mo;

  always @(negedge clk) begin
    a_mdone = 1'b0;
    if (!rst_n) a_track = 1'b0;
    if (a_busy) begin
      if (a_track && (a_if.mm_x !== a_x || a_if.mm_y !== a_y)) a_unstable++;
      a_cnt--;
      if (a_cnt == 0) begin
        a_mdone = 1'b1;
        a_mo    = 8'(longint'(a_x) * longint'(a_y) % longint'(a_nn));
        a_busy  = 1'b0;
      end
    end
    if (a_if.mm_start) begin
      if (a_busy) a_overlap++;
      a_x = a_if.mm_x; a_y = a_if.mm_y; a_nn = a_if.mm_n;
      a_busy = 1'b1; a_track = 1'b1; a_cnt = a_lat; a_starts++;
      if (a_x == a_y) a_sq++; else a_mu++;
    end
  end

  always @(posedge clk) begin
    if (a_req && a_ready) a_acc++;
    if (a_done) a_dones++;
  end

  // ---------------- instance B, N=16 ----------------
  logic        b_req = 1'b0;
  logic [15:0] b_m = '0, b_e = '0, b_n = '0;
  logic [15:0] b_o;
  logic        b_ready, b_done, b_err;
  modexp_seq_ctrl_if #(.N(16)) b_if ();
  modexp_seq_ctrl #(.N(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .ready_o(b_ready),
    .m_i(b_m), .e_i(b_e), .n_i(b_n), .o_o(b_o), .done_o(b_done), .err_o(b_err),
    .mm(b_if)
  );

  logic        b_mdone = 1'b0;
  logic [15:0] b_mo = '0, b_x = '0, b_y = '0, b_nn = '0;
  int b_cnt = 0, b_starts = 0, b_sq = 0, b_mu = 0, b_unstable = 0, b_overlap = 0, b_dones = 0;
  bit b_busy = 1'b0, b_track = 1'b0;
  assign b_if.mm_done = b_mdone;
  assign b_if.mm_o    = b_mo;

  always @(negedge clk) begin
    b_mdone = 1'b0;
    if (!rst_n) b_track = 1'b0;
    if (b_busy) begin
      if (b_track && (b_if.mm_x !== b_x || b_if.mm_y !== b_y)) b_unstable++;
      b_cnt--;
      if (b_cnt == 0) begin
        b_mdone = 1'b1;
        b_mo    = 16'(longint'(b_x) * longint'(b_y) % longint'(b_nn));
        b_busy  = 1'b0;
      end
    end
    if (b_if.mm_start) begin
      if (b_busy) b_overlap++;
      b_x = b_if.mm_x; b_y = b_if.mm_y; b_nn = b_if.mm_n;
      b_busy = 1'b1; b_track = 1'b1; b_cnt = int'($urandom_range(6, 1)); b_starts++;
      if (b_x == b_y) b_sq++; else b_mu++;
    end
  end

  always @(posedge clk) if (b_done) b_dones++;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done_a(output int k);
    k = 1;
    while (!a_done && k < 400) begin
      tick();
      k++;
    end
    check("a_done_seen", 32'(a_done), 1);
  endtask

  task automatic job_a(input logic [7:0] m, e, n, output logic [7:0] o, output logic err,
                       output int cyc, output int st, output int sq, output int mu,
                       output int dn);
    int s0, q0, u0, d0, k;
    s0 = a_starts; q0 = a_sq; u0 = a_mu; d0 = a_dones;
    a_m = m; a_e = e; a_n = n; a_req = 1'b1;
    tick();
    a_req = 1'b0;
    wait_done_a(k);
    o = a_o; err = a_err; cyc = k + 1;
    tick();
    check("a_ready_after_done", 32'(a_ready), 1);
    check("a_done_one_cycle", 32'(a_done), 0);
    st = a_starts - s0; sq = a_sq - q0; mu = a_mu - u0; dn = a_dones - d0;
  endtask

  task automatic job_b(input logic [15:0] m, e, n, output logic [15:0] o, output logic err,
                       output int st, output int sq, output int mu, output int dn);
    int s0, q0, u0, d0, k;
    s0 = b_starts; q0 = b_sq; u0 = b_mu; d0 = b_dones;
    b_m = m; b_e = e; b_n = n; b_req = 1'b1;
    tick();
    b_req = 1'b0;
    k = 1;
    while (!b_done && k < 600) begin
      tick();
      k++;
    end
    check("b_done_seen", 32'(b_done), 1);
    o = b_o; err = b_err;
    tick();
    st = b_starts - s0; sq = b_sq - q0; mu = b_mu - u0; dn = b_dones - d0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, 32'(a_ready), 1);
    check({tag, "_done"}, 32'(a_done), 0);
    check({tag, "_err"}, 32'(a_err), 0);
    check({tag, "_o"}, 32'(a_o), 0);
    check({tag, "_mm_start"}, 32'(a_if.mm_start), 0);
    check({tag, "_mm_x"}, 32'(a_if.mm_x), 0);
    check({tag, "_mm_y"}, 32'(a_if.mm_y), 0);
    check({tag, "_mm_n"}, 32'(a_if.mm_n), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  o8;
    logic [15:0] o16;
    logic        er;
    int cyc, st, sq, mu, dn, s0, d0, k;

    #3 rst_n = 1'b0;
    tick();
    check_reset_a("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // 3^5 mod 7 = 5 with a 1-cycle multiplier: 2 squares, 1 multiply, 15 cycles
    job_a(8'd3, 8'd5, 8'd7, o8, er, cyc, st, sq, mu, dn);
    check("t1_o", 32'(o8), 5);
    check("t1_err", 32'(er), 0);
    check("t1_squares", st > 0 ? 32'(sq) : 32'hFFFF, 2);
    check("t1_mults", 32'(mu), 1);
    check("t1_dones", 32'(dn), 1);
    check("t1_cycles", 32'(cyc), 15);
    check("t1_mm_n", 32'(a_if.mm_n), 7);

    // 4^13 mod 497 = 445 with random 1..6 latency: 3 squares, 2 multiplies
    job_b(16'd4, 16'd13, 16'd497, o16, er, st, sq, mu, dn);
    check("t2_o", 32'(o16), 445);
    check("t2_err", 32'(er), 0);
    check("t2_ops", 32'(st), 5);
    check("t2_squares", 32'(sq), 3);
    check("t2_mults", 32'(mu), 2);
    check("t2_dones", 32'(dn), 1);

    // e = 0 gives 1 with no multiplier traffic
    job_a(8'd5, 8'd0, 8'd7, o8, er, cyc, st, sq, mu, dn);
    check("t3a_o", 32'(o8), 1);
    check("t3a_err", 32'(er), 0);
    check("t3a_ops", 32'(st), 0);
    check("t3a_cycles", 32'(cyc), 3);

    // 2^129 mod 11 = 6: leading one at bit 7, 7 squares and 1 multiply
    job_a(8'd2, 8'h81, 8'd11, o8, er, cyc, st, sq, mu, dn);
    check("t3b_o", 32'(o8), 6);
    check("t3b_squares", 32'(sq), 7);
    check("t3b_mults", 32'(mu), 1);
    check("t3b_cycles", 32'(cyc), 20);

    // rejected jobs
    job_a(8'd0, 8'd3, 8'd1, o8, er, cyc, st, sq, mu, dn);
    check("t4a_err", 32'(er), 1);
    check("t4a_o", 32'(o8), 0);
    check("t4a_ops", 32'(st), 0);
    job_a(8'd9, 8'd3, 8'd9, o8, er, cyc, st, sq, mu, dn);
    check("t4b_err", 32'(er), 1);
    check("t4b_ops", 32'(st), 0);
    check("t4b_dones", 32'(dn), 1);

    // req held high across two jobs, then a stray mm_done while idle
    s0 = a_acc; d0 = a_dones;
    a_m = 8'd3; a_e = 8'd5; a_n = 8'd7; a_req = 1'b1;
    tick();
    wait_done_a(k);
    check("t5_o1", 32'(a_o), 5);
    check("t5_busy_during", 32'(a_acc - s0), 1);
    tick();
    check("t5_ready_after_done", 32'(a_ready), 1);
    tick();
    check("t5_second_accepted", 32'(a_ready), 0);
    wait_done_a(k);
    check("t5_o2", 32'(a_o), 5);
    a_req = 1'b0;
    tick();
    check("t5_accepts", 32'(a_acc - s0), 2);
    a_spur = 1'b1;
    tick();
    a_spur = 1'b0;
    tick();
    tick();
    check("t5_spur_o", 32'(a_o), 5);
    check("t5_spur_ready", 32'(a_ready), 1);
    check("t5_dones", 32'(a_dones - d0), 2);

    // asynchronous reset while a square is outstanding
    a_lat = 6;
    s0 = a_starts; d0 = a_dones;
    a_m = 8'd3; a_e = 8'd5; a_n = 8'd7; a_req = 1'b1;
    tick();
    a_req = 1'b0;
    k = 0;
    while (a_starts == s0 && k < 50) begin
      tick();
      k++;
    end
    check("t6_start_seen", 32'(a_starts - s0), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_a("t6_async");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("t6_no_done", 32'(a_dones - d0), 0);
    check("t6_o_after", 32'(a_o), 0);
    check("t6_ready_after", 32'(a_ready), 1);
    a_lat = 1;
    job_a(8'd3, 8'd5, 8'd7, o8, er, cyc, st, sq, mu, dn);
    check("t6_rerun_o", 32'(o8), 5);
    check("t6_rerun_ops", 32'(st), 3);

    check("a_operands_stable", 32'(a_unstable), 0);
    check("a_no_overlap", 32'(a_overlap), 0);
    check("b_operands_stable", 32'(b_unstable), 0);
    check("b_no_overlap", 32'(b_overlap), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
